// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbitration slice.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;
  localparam int unsigned N_REQ_MAX   = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_RISE,
    WAIT_FALL,
    GAP,
    DECIDE,
    RELEASE
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning from ptr upward, wrapping.
module uart_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest-to-ptr request wins last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      cand = IW'((32'(ptr) + 32'(k)) % N);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte requesters,
// with optional grant lock across multi-byte packets.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned GAP_CYC = 0,
  parameter int unsigned RISE_TO = 15
) (
  input  logic                         sclk,
  input  logic                         srst,
  input  logic [N_REQ-1:0]             req_vld,
  input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ack,
  output logic [N_REQ-1:0]             grant,
  output logic                         tx_trig,
  output logic [UART_BYTE_W-1:0]       tx_data,
  input  logic                         tx_en,
  output logic                         busy,
  output logic                         err_to
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] RISE_LIM = CNT_W'(RISE_TO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  arb_state_e             state, state_nxt;
  logic [IDX_W-1:0]       ptr, ptr_nxt;
  logic [IDX_W-1:0]       g_idx, g_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   lock, lock_nxt;
  logic [N_REQ-1:0]       grant_nxt, ack_nxt;
  logic                   trig_nxt, busy_nxt, err_nxt;
  logic [UART_BYTE_W-1:0] data_nxt;

  logic [N_REQ-1:0]       pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic [UART_BYTE_W-1:0] req_bytes [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[i*UART_BYTE_W +: UART_BYTE_W];
  end

  uart_rr_pick #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) u_pick (
    .req (req_vld),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Next-state and next-output logic; all outputs are registered from these.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    g_nxt     = g_idx;
    cnt_nxt   = cnt;
    lock_nxt  = lock;
    grant_nxt = grant;
    ack_nxt   = '0;
    trig_nxt  = 1'b0;
    data_nxt  = tx_data;
    err_nxt   = err_to;

    case (state)
      IDLE: begin
        if (|req_vld) begin
          g_nxt     = pick_idx;
          grant_nxt = pick_gnt;
          ack_nxt   = pick_gnt;
          trig_nxt  = 1'b1;
          data_nxt  = req_bytes[pick_idx];
          lock_nxt  = !req_last[pick_idx];
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        cnt_nxt   = CNT_W'(1);
        state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (tx_en) begin
          state_nxt = WAIT_FALL;
        end else if (cnt == RISE_LIM) begin
          err_nxt   = 1'b1;
          state_nxt = RELEASE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_FALL: begin
        if (!tx_en) begin
          if (GAP_CYC == 0) begin
            state_nxt = DECIDE;
          end else begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (cnt == GAP_LIM) state_nxt = DECIDE;
        else                cnt_nxt   = cnt + CNT_W'(1);
      end
      DECIDE: begin
        if (lock && req_vld[g_idx]) begin
          ack_nxt   = grant;
          trig_nxt  = 1'b1;
          data_nxt  = req_bytes[g_idx];
          lock_nxt  = !req_last[g_idx];
          state_nxt = LOAD;
        end else begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Entering RELEASE drops the owner and advances priority past it.
    if (state_nxt == RELEASE && state != RELEASE) begin
      grant_nxt = '0;
      lock_nxt  = 1'b0;
      ptr_nxt   = (g_idx == LAST_IDX) ? '0 : g_idx + IDX_W'(1);
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge sclk) begin
    if (!srst) begin
      state   <= IDLE;
      ptr     <= '0;
      g_idx   <= '0;
      cnt     <= '0;
      lock    <= 1'b0;
      grant   <= '0;
      req_ack <= '0;
      tx_trig <= 1'b0;
      tx_data <= '0;
      busy    <= 1'b0;
      err_to  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      g_idx   <= g_nxt;
      cnt     <= cnt_nxt;
      lock    <= lock_nxt;
      grant   <= grant_nxt;
      req_ack <= ack_nxt;
      tx_trig <= trig_nxt;
      tx_data <= data_nxt;
      busy    <= busy_nxt;
      err_to  <= err_nxt;
    end
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one `uart_tx` transmitter between `N_REQ` byte requesters. It sits between the requesting blocks and `uart_tx`:
- It accepts a byte from the current owner and pulses `tx_trig` with `tx_data`.
- It tracks `tx_en` to find the end of the frame.
- It can hold the grant across a multi-byte packet until the owner marks the last byte.

## Interface
- `N_REQ`, 4 — number of requesters, 2..8.
- `GAP_CYC`, 0 — idle `sclk` cycles inserted after each frame before the next trigger, 0..255.
- `RISE_TO`, 15 — max cycles to wait for `tx_en` to rise after `tx_trig`, 1..255.

Ports:
- `sclk`  in  1  system clock.
- `srst`  in  1  reset, synchronous, active-low.
- `req_vld`  in  `N_REQ`  requester i has a byte on its slice.
- `req_data`  in  `8*N_REQ`  byte of requester i at `[8i+7:8i]`.
- `req_last`  in  `N_REQ`  byte of requester i ends its packet.
- `req_ack`  out  `N_REQ`  one-cycle pulse: byte of requester i consumed.
- `grant`  out  `N_REQ`  one-hot current owner; all-zero when idle.
- `tx_trig`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_data`  out  8  byte to `uart_tx`, held stable from the trigger until the next load.
- `tx_en`  in  1  `uart_tx` busy, high for the duration of a frame.
- `busy`  out  1  arbiter not in IDLE.
- `err_to`  out  1  sticky flag: `tx_en` failed to rise within `RISE_TO`. Cleared only by reset.

## Operation
States:
- **IDLE**
  - Pointer `ptr` marks the highest-priority requester.
  - If any `req_vld` is set, pick the first set bit scanning `ptr`, `ptr+1`, …, wrapping modulo `N_REQ`.
  - Go to LOAD with `grant` = that one-hot.
- **LOAD** (1 cycle)
  - `tx_trig`=1, `req_ack[g]`=1, `tx_data`=`req_data[g]`.
  - Latch `lock` = !`req_last[g]`.
  - Go to WAIT_RISE.
- **WAIT_RISE**
  - On `tx_en`=1, go to WAIT_FALL.
  - If a counter reaches `RISE_TO` first: set `err_to`, clear `lock`, go to RELEASE.
- **WAIT_FALL**
  - On `tx_en`=0, go to GAP. If `GAP_CYC`=0, skip GAP and go directly to DECIDE.
- **GAP**
  - Count `GAP_CYC` cycles, then go to DECIDE.
- **DECIDE** (1 cycle)
  - If `lock` and `req_vld[g]`: go to LOAD, same owner.
  - Otherwise go to RELEASE. This includes `lock` set with `req_vld[g]`=0: the lock is dropped.
- **RELEASE** (1 cycle)
  - `ptr` = (g+1) mod `N_REQ`, `grant`=0, go to IDLE.

Rules:
- Requests not granted are ignored (not queued); requesters hold `req_vld`/`req_data` until acked.
- `req_vld` changes of non-owners never affect the current owner.
- `req_data`/`req_last` are sampled only in LOAD.
- Arbitration happens only in IDLE, so a packet is never interleaved with another requester's bytes.
- Reset, including mid-frame, applies the reset values below and does not wait for `tx_en` to fall. `uart_tx` shares `srst`.

## Timing
- Reset values: `state`=IDLE, `ptr`=0, `grant`=0, `req_ack`=0, `tx_trig`=0, `tx_data`=8'h00, `busy`=0, `err_to`=0, `lock`=0.
- All outputs are registered.
- `req_vld` sampled high in IDLE at edge t → `grant`, `tx_trig`, `req_ack` and `tx_data` are all valid in cycle t+1. `tx_trig` and `req_ack` are high for exactly that one cycle.
- `busy` is high from LOAD through RELEASE inclusive.
- Back-to-back bytes in a locked packet: next `tx_trig` comes 2+`GAP_CYC` cycles after the `tx_en` falling edge is sampled.
  - 1 cycle in DECIDE, 1 cycle to register LOAD; GAP cycles add to this.
- New arbitration after a packet: RELEASE and IDLE add 2 cycles.
- `tx_en` already high when LOAD occurs: WAIT_RISE exits on the first cycle it is sampled high.
- `RISE_TO` counts from the cycle after LOAD.
- Simultaneous requests in the same cycle are resolved purely by `ptr`.

## Structure
- Package `uart_pkg`:
  - state enum (IDLE, LOAD, WAIT_RISE, WAIT_FALL, GAP, DECIDE, RELEASE)
  - `UART_BYTE_W`=8
  - `N_REQ_MAX`=8
- Sub-module `uart_rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector and `ptr`.
  - Outputs: one-hot `gnt` and index `idx`.
  - Reusable by other arbiters in the design.
- Top holds the FSM, the GAP/timeout counter (8 bits) and the output registers. It instantiates nothing else.

## Test plan
- **Single byte.** `req_vld`=4'b0010, `req_data[15:8]`=8'h55, `req_last[1]`=1; bench `uart_tx` present.
  - One `tx_trig` with `tx_data`=8'h55 and `req_ack[1]` in the same cycle; `grant`=4'b0010 until RELEASE; `ptr`=2 afterwards.
- **Round robin.** All four requesters valid with `req_last`=1 and bytes 8'hA0..A3; each drops `req_vld` after its ack.
  - Trigger order is 0, 1, 2, 3 with data A0, A1, A2, A3; then re-raise requester 0 plus requester 3 with `ptr`=0 → 0 is served first.
- **Packet lock.** Requester 2 sends 3 bytes 8'h11, 8'h22, 8'h33 with `req_last` on the third; requester 0 valid throughout.
  - Requester 0 is not granted until after 8'h33 completes; with `GAP_CYC`=4 the triggers are spaced at `tx_en` fall + 6 cycles.
- **Lock drop.** Requester 1 sends a non-last byte, then deasserts `req_vld[1]`.
  - DECIDE goes to RELEASE, `grant`=0, and the next requester is served.
- **Timeout.** Tie `tx_en`=0, `RISE_TO`=15.
  - `err_to` rises 15 cycles after LOAD; the arbiter returns to IDLE and keeps serving requests.
- **Reset mid-frame.** Drive `srst`=0 for 1 cycle during WAIT_FALL.
  - On the next edge all outputs take their reset values and `ptr`=0; a request afterwards gets its trigger one cycle after it is sampled.
